// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, bit-timing
// constants at 16x oversampling, and the per-frame configuration record.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    localparam logic [3:0] CNT_MID = 4'd7;
    localparam logic [3:0] CNT_END = 4'd15;

    localparam logic [3:0] BITNUM_MIN = 4'd5;
    localparam logic [3:0] BITNUM_MAX = 4'd8;

    typedef struct packed {
        logic       par_en;
        logic       par_odd;
        logic       stop_en;
        logic [2:0] last_bit;
    } frame_cfg_t;

    // Index of the final data bit; an unsupported width falls back to 8 bits.
    function automatic logic [2:0] last_bit_idx(input logic [3:0] bitnum);
        if (bitnum >= BITNUM_MIN && bitnum <= BITNUM_MAX)
            return 3'(bitnum - 4'd1);
        else
            return 3'd7;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-frame result bus: byte, one-cycle valid strobe and error flags.
interface uart_rx_if;

    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;

    modport master (
        output o_data,
        output o_data_valid,
        output o_parity_err,
        output o_frame_err
    );

    modport slave (
        input o_data,
        input o_data_valid,
        input o_parity_err,
        input o_frame_err
    );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; flops reset to
// the idle-high level so reset never fabricates a falling edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clkx16,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments make every stage capture its
    // predecessor's old value, which is what forms a real shift chain.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= i_d;
            for (int i = 1; i < STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver at 16x oversampling: 5-8 data bits LSB first, optional
// parity bit and optional single stop bit, mid-bit sampling on cnt==7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clkx16,
    input  logic       i_rst,
    input  logic       i_exist_oddcheck,
    input  logic       i_exist_evencheck,
    input  logic       i_exist_stop,
    input  logic [3:0] i_bitnum,
    input  logic       i_rx,
    uart_rx_if.master  rx_out
);

    logic        rx_s;
    logic        rx_prev;
    logic        fall;
    logic        at_mid;
    logic        at_end;
    logic        par_expect;
    logic        frame_done;

    uart_state_e state;
    logic [3:0]  cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        par_err_q;
    frame_cfg_t  cfg;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clkx16(i_clkx16),
        .i_rst   (i_rst),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    assign fall   = rx_prev & ~rx_s;
    assign at_mid = (cnt == CNT_MID);
    assign at_end = (cnt == CNT_END);

    // Unreceived upper bits of shift_q are zero, so reducing the whole byte
    // gives the XOR of exactly the received data bits.
    always_comb begin
        // NOTE: every output of this block is given a value before the case,
        // so no path leaves one unassigned and no latch is inferred.
        par_expect = cfg.par_odd ? (^shift_q) : ~(^shift_q);
        frame_done = 1'b0;
        case (state)
            ST_DATA:  frame_done = at_end && (bit_cnt == cfg.last_bit)
                                   && !cfg.par_en && !cfg.stop_en;
            ST_CHECK: frame_done = at_end && !cfg.stop_en;
            ST_STOP:  frame_done = at_mid;
            default:  frame_done = 1'b0;
        endcase
    end

    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            state                <= ST_IDLE;
            cnt                  <= 4'd0;
            bit_cnt              <= 3'd0;
            shift_q              <= 8'd0;
            par_err_q            <= 1'b0;
            cfg                  <= '0;
            rx_prev              <= 1'b1;
            rx_out.o_data        <= 8'd0;
            rx_out.o_data_valid  <= 1'b0;
            rx_out.o_parity_err  <= 1'b0;
            rx_out.o_frame_err   <= 1'b0;
        end else begin
            rx_prev             <= rx_s;
            rx_out.o_data_valid <= frame_done;

            if (frame_done) begin
                rx_out.o_data       <= shift_q;
                rx_out.o_parity_err <= cfg.par_en & par_err_q;
                rx_out.o_frame_err  <= cfg.stop_en & (state == ST_STOP) & ~rx_s;
            end

            case (state)
                ST_IDLE: begin
                    cnt     <= 4'd0;
                    bit_cnt <= 3'd0;
                    if (fall) begin
                        state     <= ST_START;
                        shift_q   <= 8'd0;
                        par_err_q <= 1'b0;
                        cfg       <= '{
                            par_en:   i_exist_oddcheck | i_exist_evencheck,
                            par_odd:  i_exist_oddcheck,
                            stop_en:  i_exist_stop,
                            last_bit: last_bit_idx(i_bitnum)
                        };
                    end
                end

                ST_START: begin
                    cnt <= cnt + 4'd1;
                    if (at_mid && rx_s) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else if (at_end) begin
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    cnt <= cnt + 4'd1;
                    if (at_mid)
                        shift_q[bit_cnt] <= rx_s;
                    if (at_end) begin
                        if (bit_cnt == cfg.last_bit) begin
                            bit_cnt <= 3'd0;
                            if (cfg.par_en)
                                state <= ST_CHECK;
                            else if (cfg.stop_en)
                                state <= ST_STOP;
                            else
                                state <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                ST_CHECK: begin
                    cnt <= cnt + 4'd1;
                    if (at_mid)
                        par_err_q <= (rx_s != par_expect);
                    if (at_end)
                        state <= cfg.stop_en ? ST_STOP : ST_IDLE;
                end

                // Leave at mid-stop so a start bit right after is still seen.
                ST_STOP: begin
                    cnt <= cnt + 4'd1;
                    if (at_mid) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL expose parameter SYNC_STAGES, default 2, number of input synchronizer flops on i_rx.
REQ-002 SHALL expose i_clkx16  input  1  clock at 16x the bit rate.
REQ-003 SHALL expose i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL expose i_exist_oddcheck  input  1  a parity bit is present, expected value = XOR of the data bits.
REQ-005 SHALL expose i_exist_evencheck  input  1  a parity bit is present, expected value = inverted XOR of the data bits.
REQ-006 SHALL expose i_exist_stop  input  1  a 1-bit stop bit is present.
REQ-007 SHALL expose i_bitnum  input  4  number of data bits, 5 to 8.
REQ-008 SHALL expose i_rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL expose o_data  output  8  received byte, LSB first on the line, unused upper bits zero.
REQ-010 SHALL expose o_data_valid  output  1  one-cycle pulse when o_data and the error flags are updated.
REQ-011 SHALL expose o_parity_err  output  1  parity mismatch for the frame reported with o_data_valid.
REQ-012 SHALL expose o_frame_err  output  1  stop bit sampled low for the frame reported with o_data_valid.

Function
REQ-013 SHALL pass i_rx through SYNC_STAGES flops reset to 1; all detection SHALL use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, CHECK, STOP with a 4-bit phase counter cnt and a bit counter.
REQ-015 IDLE SHALL hold cnt at 0 and SHALL move to START on a synchronized 1->0 transition.
REQ-016 On entry to START, SHALL latch the parity, stop and bitnum inputs; they SHALL stay fixed for the whole frame.
REQ-017 START SHALL sample the line at cnt==7; if it is 1 (glitch), SHALL return to IDLE with no output; if it is 0, SHALL continue to cnt==15 and then enter DATA.
REQ-018 DATA SHALL sample one bit per 16 cycles at cnt==7, shifting it in LSB first; after bitnum bits and at cnt==15, SHALL go to CHECK if parity is enabled, else to STOP if a stop bit is enabled, else to IDLE.
REQ-019 CHECK SHALL sample at cnt==7 and compare the sample against the expected parity; at cnt==15, SHALL go to STOP if a stop bit is enabled, else to IDLE.
REQ-020 If both parity inputs are 1, the odd-check rule SHALL take precedence.
REQ-021 STOP SHALL sample at cnt==7, SHALL set the frame error if the sample is 0, and SHALL go to IDLE in the same cycle so that a start bit arriving immediately after is detected.
REQ-022 o_data_valid SHALL pulse for exactly one cycle on the final transition of the frame into IDLE: STOP cnt==7, or cnt==15 of the last DATA/CHECK bit when no stop bit is enabled.
REQ-023 o_data, o_parity_err and o_frame_err SHALL be registered on that same edge and SHALL hold until the next pulse.
REQ-024 o_parity_err SHALL be 0 when parity is disabled; o_frame_err SHALL be 0 when the stop bit is disabled.
REQ-025 A latched bitnum outside 5..8 SHALL be treated as 8.
REQ-026 A line transition during START, DATA, CHECK or STOP SHALL NOT restart the frame.

Reset
REQ-027 Reset SHALL force IDLE, cnt=0, the bit counter=0, synchronizer flops=1, o_data=0, o_data_valid=0, o_parity_err=0 and o_frame_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_data_valid pulse; after release, reception SHALL resume on the next falling edge.

Structure
REQ-029 State encodings and the constants for the mid-bit sample point (7) and the bit end (15) SHALL live in a shared uart package also used by the transmitter.
REQ-030 The input synchronizer SHALL be a sub-module named uart_sync.

Verification
REQ-031 8 data bits, no parity, with stop, byte 0xA5 at 16x -> one pulse, o_data=0xA5, both error flags 0.
REQ-032 7 data bits, odd-check, with stop, byte 0x35 with correct parity bit 0, then the same frame with parity bit 1 -> o_data=0x35 both times; o_parity_err 0 then 1.
REQ-033 5 data bits, even-check, no stop, byte 0x1F followed by a 1-cycle idle and a second frame 0x0A -> two pulses: 0x1F then 0x0A, with no error flags.
REQ-034 8 data bits, with stop, stop bit driven 0, byte 0x3C -> o_data=0x3C, o_frame_err=1.
REQ-035 A 4-cycle low glitch on an idle line -> no pulse, FSM back in IDLE; a following 0x55 frame is received correctly.
REQ-036 Reset asserted during bit 3 of a 0xFF frame -> no pulse, all outputs 0; the next frame 0x81 is received correctly.
